// File: rtl/uart_rx_frame_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_if
// Payload stream from the receive framer to its sink.
//
// Handshake: the source raises pl_valid with pl_data/pl_last and keeps all
// three stable until the sink takes the byte. A byte moves on every rising
// clock edge where pl_valid && pl_ready. pl_ready may be driven freely by the
// sink; the source never waits for pl_ready before asserting pl_valid.
//
// Signals:
//   pl_data  [7:0] payload byte              (source -> sink)
//   pl_valid       pl_data is valid          (source -> sink)
//   pl_last        final byte of the frame   (source -> sink)
//   pl_ready       sink accepts pl_data      (sink -> source)
// Modports: master = framer side, slave = sink side.
// -----------------------------------------------------------------------------
interface uart_rx_frame_if;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       pl_last;

  modport master (
    output pl_data,
    output pl_valid,
    output pl_last,
    input  pl_ready
  );

  modport slave (
    input  pl_data,
    input  pl_valid,
    input  pl_last,
    output pl_ready
  );
endinterface

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// Framer behind a UART receive controller. Hunts for HDR, reads a LEN byte,
// buffers LEN payload bytes, compares an XOR checksum (LEN ^ payload) against
// the trailing CHK byte and, only for a good frame, streams the buffered
// payload out on the pl interface. Bad length, bad checksum, inter-byte
// timeout and bytes arriving while the payload is still being sent are
// dropped and reported with one-cycle pulses.
//
// Parameters:
//   HDR      header byte opening a frame
//   MAX_LEN  largest accepted payload length (2..255)
//   TIMEOUT  max idle clk cycles between bytes inside a frame (>= 2)
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rx_data      received byte, valid with rx_done_sig
//   rx_done_sig  one-cycle strobe per received byte
//   pl           payload stream (master modport)
//   frm_ok       pulse: checksum matched, payload follows
//   chk_err      pulse: checksum mismatch
//   len_err      pulse: LEN is 0 or above MAX_LEN
//   to_err       pulse: inter-byte timeout
//   ovr_err      pulse: byte dropped while sending
//   busy         state is not HUNT
//   dbg_state    current FSM state (HUNT=0 LEN=1 PAYLOAD=2 CHK=3 SEND=4)
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_rx_frame #(
  parameter logic [7:0] HDR     = 8'hAA,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done_sig,
  uart_rx_frame_if.master        pl,
  output logic                   frm_ok,
  output logic                   chk_err,
  output logic                   len_err,
  output logic                   to_err,
  output logic                   ovr_err,
  output logic                   busy,
  output logic [2:0]             dbg_state
);

  localparam int LW = $clog2(MAX_LEN + 1);  // len and counters
  localparam int IW = $clog2(MAX_LEN);      // buffer index
  localparam int TW = $clog2(TIMEOUT);      // idle counter

  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [LW-1:0] ONE       = LW'(1);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_SEND    = 3'd4
  } state_t;

  state_t        state;
  logic [LW-1:0] len;
  logic [LW-1:0] wr_cnt;
  logic [LW-1:0] rd_cnt;
  logic [LW-1:0] rd_nxt;
  logic [7:0]    chk;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    buf_mem [MAX_LEN];

  logic in_frame;
  logic idle_hit;
  logic xfer;

  // The idle counter only matters between HDR and CHK.
  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  // A strobe at the terminal count wins over the timeout.
  assign idle_hit = in_frame && !rx_done_sig && (idle_cnt == IDLE_LAST);
  assign xfer     = pl.pl_valid && pl.pl_ready;
  assign rd_nxt   = rd_cnt + ONE;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HUNT;
      len         <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      chk         <= '0;
      idle_cnt    <= '0;
      pl.pl_data  <= '0;
      pl.pl_valid <= 1'b0;
      pl.pl_last  <= 1'b0;
      frm_ok      <= 1'b0;
      chk_err     <= 1'b0;
      len_err     <= 1'b0;
      to_err      <= 1'b0;
      ovr_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frm_ok  <= 1'b0;
      chk_err <= 1'b0;
      len_err <= 1'b0;
      to_err  <= 1'b0;
      ovr_err <= 1'b0;

      // Held at zero outside a frame, so entering LEN starts from zero.
      if (rx_done_sig || !in_frame) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      case (state)
        S_HUNT: begin
          if (rx_done_sig && (rx_data == HDR)) begin
            state <= S_LEN;
            busy  <= 1'b1;
          end
        end

        S_LEN: begin
          if (rx_done_sig) begin
            if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
              len_err <= 1'b1;
              state   <= S_HUNT;
              busy    <= 1'b0;
            end else begin
              len    <= rx_data[LW-1:0];
              chk    <= rx_data;
              wr_cnt <= '0;
              state  <= S_PAYLOAD;
            end
          end else if (idle_hit) begin
            to_err <= 1'b1;
            state  <= S_HUNT;
            busy   <= 1'b0;
          end
        end

        S_PAYLOAD: begin
          if (rx_done_sig) begin
            buf_mem[wr_cnt[IW-1:0]] <= rx_data;
            chk <= chk ^ rx_data;
            if (wr_cnt == (len - ONE)) begin
              state <= S_CHK;
            end else begin
              wr_cnt <= wr_cnt + ONE;
            end
          end else if (idle_hit) begin
            to_err <= 1'b1;
            state  <= S_HUNT;
            busy   <= 1'b0;
          end
        end

        S_CHK: begin
          if (rx_done_sig) begin
            if (rx_data == chk) begin
              frm_ok      <= 1'b1;
              rd_cnt      <= '0;
              // First byte is presented together with frm_ok.
              pl.pl_valid <= 1'b1;
              pl.pl_data  <= buf_mem[0];
              pl.pl_last  <= (len == ONE);
              state       <= S_SEND;
            end else begin
              chk_err <= 1'b1;
              state   <= S_HUNT;
              busy    <= 1'b0;
            end
          end else if (idle_hit) begin
            to_err <= 1'b1;
            state  <= S_HUNT;
            busy   <= 1'b0;
          end
        end

        S_SEND: begin
          // Nothing can be buffered while draining; incoming bytes are lost.
          if (rx_done_sig) begin
            ovr_err <= 1'b1;
          end
          if (xfer) begin
            if (pl.pl_last) begin
              pl.pl_valid <= 1'b0;
              pl.pl_last  <= 1'b0;
              pl.pl_data  <= '0;
              state       <= S_HUNT;
              busy        <= 1'b0;
            end else begin
              // Prefetch the next byte so throughput stays at one per cycle.
              rd_cnt     <= rd_nxt;
              pl.pl_data <= buf_mem[rd_nxt[IW-1:0]];
              pl.pl_last <= (rd_nxt == (len - ONE));
            end
          end
        end

        default: begin
          state <= S_HUNT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
// Directed bench for uart_rx_frame with MAX_LEN=16 and TIMEOUT=100.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame;

  localparam logic [2:0] ST_HUNT = 3'd0;
  localparam logic [2:0] ST_CHK  = 3'd3;
  localparam logic [2:0] ST_SEND = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done_sig;
  logic       frm_ok, chk_err, len_err, to_err, ovr_err, busy;
  logic [2:0] dbg_state;

  uart_rx_frame_if pl_if ();

  uart_rx_frame #(
    .HDR     (8'hAA),
    .MAX_LEN (16),
    .TIMEOUT (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done_sig (rx_done_sig),
    .pl          (pl_if),
    .frm_ok      (frm_ok),
    .chk_err     (chk_err),
    .len_err     (len_err),
    .to_err      (to_err),
    .ovr_err     (ovr_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one strobe; returns on the falling edge after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    rx_done_sig = 1'b1;
    @(negedge clk);
    rx_done_sig = 1'b0;
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i]);
    tx_q.delete();
  endtask

  // scoreboard: with pl_ready high, one expected byte per cycle
  task automatic drain();
    int n;
    logic [7:0] exp;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      exp = exp_q.pop_front();
      check("pl_valid", {31'd0, pl_if.pl_valid}, 32'd1);
      check("pl_data", {24'd0, pl_if.pl_data}, {24'd0, exp});
      check("pl_last", {31'd0, pl_if.pl_last}, (i == n - 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("valid_after", {31'd0, pl_if.pl_valid}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {17'd0, pl_if.pl_data, pl_if.pl_valid, pl_if.pl_last, frm_ok, chk_err,
                len_err, to_err, ovr_err, busy}, 32'd0);
    check({tag, "_state"}, {29'd0, dbg_state}, {29'd0, ST_HUNT});
  endtask

  initial begin
    int  n;
    logic seen;

    // reset
    rst            = 1'b1;
    rx_data        = 8'h00;
    rx_done_sig    = 1'b0;
    pl_if.pl_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");

    // good frame
    tx_q = {8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_q();
    check("good_frm_ok", {31'd0, frm_ok}, 32'd1);
    exp_q = {8'h11, 8'h22, 8'h33};
    drain();
    check("good_frm_ok_pulse", {31'd0, frm_ok}, 32'd0);

    // checksum error, then resync through a junk byte
    tx_q = {8'hAA, 8'h02, 8'h10, 8'h20, 8'h31};
    send_q();
    check("chk_err", {31'd0, chk_err}, 32'd1);
    check("chk_err_no_valid", {31'd0, pl_if.pl_valid}, 32'd0);
    check("chk_err_no_ok", {31'd0, frm_ok}, 32'd0);
    @(negedge clk);
    check("chk_err_pulse", {31'd0, chk_err}, 32'd0);
    check("chk_err_busy", {31'd0, busy}, 32'd0);
    tx_q = {8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
    send_q();
    check("resync_frm_ok", {31'd0, frm_ok}, 32'd1);
    exp_q = {8'h7E};
    drain();

    // length bounds
    tx_q = {8'hAA, 8'h00};
    send_q();
    check("len_zero", {31'd0, len_err}, 32'd1);
    check("len_zero_busy", {31'd0, busy}, 32'd0);
    tx_q = {8'hAA, 8'h11};
    send_q();
    check("len_over", {31'd0, len_err}, 32'd1);
    check("len_over_state", {29'd0, dbg_state}, {29'd0, ST_HUNT});
    tx_q = {8'hAA, 8'h10};
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    tx_q.push_back(8'h10);
    send_q();
    check("len_max_frm_ok", {31'd0, frm_ok}, 32'd1);
    check("len_max_no_len_err", {31'd0, len_err}, 32'd0);
    drain();

    // timeout: to_err on the 100th edge after the last strobe
    tx_q = {8'hAA, 8'h02, 8'h41};
    send_q();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (to_err) seen = 1'b1;
    end
    check("to_err_cycles", n, 32'd100);
    check("to_state", {29'd0, dbg_state}, {29'd0, ST_HUNT});
    check("to_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("to_err_pulse", {31'd0, to_err}, 32'd0);

    // strobe landing on the terminal count is taken, no timeout
    tx_q = {8'hAA, 8'h02, 8'h41};
    send_q();
    repeat (98) @(negedge clk);
    send_byte(8'h42);
    check("to_race_no_err", {31'd0, to_err}, 32'd0);
    check("to_race_state", {29'd0, dbg_state}, {29'd0, ST_CHK});
    send_byte(8'h01);
    check("to_race_frm_ok", {31'd0, frm_ok}, 32'd1);
    exp_q = {8'h41, 8'h42};
    drain();

    // overrun under backpressure
    pl_if.pl_ready = 1'b0;
    tx_q = {8'hAA, 8'h02, 8'hA5, 8'h5A, 8'hFD};
    send_q();
    check("ovr_frm_ok", {31'd0, frm_ok}, 32'd1);
    tx_q = {8'hAA, 8'h13, 8'hAA};
    foreach (tx_q[i]) begin
      send_byte(tx_q[i]);
      check("ovr_err", {31'd0, ovr_err}, 32'd1);
      check("ovr_hold_data", {24'd0, pl_if.pl_data}, 32'hA5);
      check("ovr_hold_last", {31'd0, pl_if.pl_last}, 32'd0);
      check("ovr_state", {29'd0, dbg_state}, {29'd0, ST_SEND});
    end
    tx_q.delete();
    @(negedge clk);
    check("ovr_pulse_end", {31'd0, ovr_err}, 32'd0);
    check("ovr_hold_valid", {31'd0, pl_if.pl_valid}, 32'd1);
    pl_if.pl_ready = 1'b1;
    exp_q = {8'hA5, 8'h5A};
    drain();
    check("ovr_hdr_dropped", {29'd0, dbg_state}, {29'd0, ST_HUNT});

    // reset mid-frame
    tx_q = {8'hAA, 8'h03, 8'h01};
    send_q();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("rst_mid_frame");
    tx_q = {8'hAA, 8'h02, 8'hC3, 8'h3C, 8'hFD};
    send_q();
    check("post_rst_frm_ok", {31'd0, frm_ok}, 32'd1);
    exp_q = {8'hC3, 8'h3C};
    drain();

    // reset mid-send
    pl_if.pl_ready = 1'b0;
    tx_q = {8'hAA, 8'h01, 8'h5C, 8'h5D};
    send_q();
    check("send_valid_before_rst", {31'd0, pl_if.pl_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pl_if.pl_ready = 1'b1;
    check_idle_outputs("rst_mid_send");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Receive-side framer placed directly downstream of the UART receive controller. It consumes the controller's byte strobe (`rx_done_sig`) and byte (`rx_data`), hunts for a header byte, and captures a length-prefixed payload into an internal buffer. It checks an XOR checksum and, only on a good frame, streams the payload out over a valid/ready interface. Bad, oversize, stalled and overrunning traffic is dropped and flagged with one-cycle error pulses.

## Interface
- `HDR`, default 8'hAA, header byte that opens a frame
- `MAX_LEN`, default 16, maximum payload length in bytes (2..255)
- `TIMEOUT`, default 50000, maximum clk cycles allowed between bytes inside a frame
- One clock; reset is synchronous and active-high.
- `clk` in 1: system clock, all logic on its rising edge
- `rst` in 1: synchronous active-high reset
- `rx_data` in 8: received byte, valid while `rx_done_sig` is high
- `rx_done_sig` in 1: one-cycle strobe per received byte
- `pl_data` out 8: payload byte
- `pl_valid` out 1: `pl_data` is valid
- `pl_ready` in 1: sink accepts `pl_data`
- `pl_last` out 1: the current `pl_data` is the final payload byte
- `frm_ok` out 1: pulse, checksum matched
- `chk_err` out 1: pulse, checksum mismatch
- `len_err` out 1: pulse, LEN is 0 or greater than `MAX_LEN`
- `to_err` out 1: pulse, inter-byte timeout
- `ovr_err` out 1: pulse, byte dropped during SEND
- `busy` out 1: state is not HUNT

## Operation
- Frame format: `HDR`, LEN, LEN payload bytes, CHK.
- CHK is the XOR of LEN and all payload bytes.
- States are HUNT, LEN, PAYLOAD, CHK and SEND. Transitions happen only on a `rx_done_sig` strobe, except for SEND and the timeout.
- HUNT: a byte equal to `HDR` moves to LEN. Any other byte is ignored without raising a flag.
- LEN: a byte of 0 or a byte greater than `MAX_LEN` pulses `len_err` and returns to HUNT. Otherwise:
  - store len
  - set chk to the byte
  - clear wr_cnt
  - move to PAYLOAD
- PAYLOAD, for each byte:
  - write buf[wr_cnt] and set chk to chk XOR byte
  - on the byte where wr_cnt equals len-1, move to CHK
  - otherwise increment wr_cnt
- CHK:
  - if the byte equals chk, pulse `frm_ok`, clear rd_cnt and move to SEND
  - otherwise pulse `chk_err` and move to HUNT
- SEND:
  - `pl_valid`=1, `pl_data`=buf[rd_cnt], `pl_last`=(rd_cnt==len-1)
  - a transfer happens on `pl_valid` && `pl_ready`; it increments rd_cnt
  - the transfer with `pl_last` returns to HUNT
- Backpressure: while `pl_valid`=1 and `pl_ready`=0, `pl_data` and `pl_last` hold stable.
- Overrun: every strobe received in SEND is discarded and pulses `ovr_err`. A dropped `HDR` byte does not open a frame.
- Timeout: an idle counter clears on every strobe and on entering LEN. In LEN, PAYLOAD or CHK, when it reaches TIMEOUT-1 the block pulses `to_err` and goes to HUNT. The counter does not run in HUNT or SEND.
- Simultaneous events: a strobe in the same cycle as the timeout terminal count is processed normally, and the timeout does not fire.
- Widths:
  - len and the counters are clog2(MAX_LEN+1) bits
  - chk is 8 bits
  - the idle counter is clog2(TIMEOUT) bits
  - the buffer is MAX_LEN×8 registers or distributed RAM

## Timing
- Reset values:
  - all outputs are 0: `pl_data`=8'h00, `pl_valid`, `pl_last`, all pulses and `busy`
  - state is HUNT; len, chk and the counters are 0
- Reset mid-frame or mid-SEND discards everything. `pl_valid` is low in the cycle after `rst`.
- All outputs are registered.
- Status and error pulses are high for exactly one cycle, the cycle after the triggering strobe or terminal count.
- `frm_ok` and the first `pl_valid` rise in the same cycle, one cycle after the CHK strobe.
- With `pl_ready` held high, throughput is one byte per cycle; a LEN-byte frame drains in LEN cycles.
- `busy` reflects the registered state.

## Test plan
- Good frame: strobe AA 03 11 22 33 03 with `pl_ready`=1. Required: `frm_ok` pulse, then 11, 22, 33 on consecutive cycles, `pl_last` only on 33, `busy` low afterwards.
- Checksum error and resync: AA 02 10 20 31 (the correct CHK is 0x32). Required: `chk_err` pulse and no `pl_valid`. Then 55 AA 01 7E 7F gives `frm_ok` and a single byte 7E with `pl_last`=1.
- Length bounds: AA 00 gives `len_err`. AA 11 with `MAX_LEN`=16 gives `len_err`. A 16-byte frame 00..0F with CHK 0x10 is accepted and output in order.
- Timeout: with `TIMEOUT`=100, send AA 02 41, then wait 100 cycles. Required: `to_err` at idle count 99 and state HUNT.
- Overrun/backpressure: good frame AA 02 A5 5A FD with `pl_ready`=0. Send 3 strobes during SEND. Required: 3 `ovr_err` pulses, `pl_data`=A5 held stable, and after `pl_ready`=1 the outputs A5, 5A follow unchanged.
- Reset mid-frame: assert `rst` for 1 cycle after AA 03 01. Required: all outputs 0 and a following good frame received correctly.
